// File: rtl/axi_sram_pkg.sv
// Shared types and constants for the AXI SRAM responder.
// FSM state encodings, the fixed transfer size and the stall LFSR shape.
package axi_sram_pkg;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_DATA  = 2'd2
  } rd_state_e;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  localparam logic [2:0] AXI_SIZE_4B = 3'd2;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam int unsigned       LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/sram_1r1w_be.sv
// 2^AW x 32 SRAM with one synchronous read port and one byte-enabled write port.
// A read and a write to the same word on one edge return the old contents.
module sram_1r1w_be #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem_q[raddr];
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI responder: INCR burst reads and single-beat writes into sram_1r1w_be.
// Define AXI_SLAVE_STALL_EN to insert pseudo-random LFSR wait states.
//
// state    | meaning
// RD_IDLE  | arready high, waiting for AR
// RD_FETCH | SRAM read of the current word in flight
// RD_DATA  | beat on R; next word fetched on a non-last handshake
// WR_IDLE  | collecting AW and W in any order
// WR_RESP  | SRAM written, bvalid high until bready
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int          MEM_AW     = 12,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_arid,
  input  logic [31:0] s_axi_araddr,
  input  logic [3:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [3:0]  s_axi_rid,
  output logic [31:0] s_axi_rdata,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  rd_state_e         rd_state_q, rd_state_d;
  logic [3:0]        rd_id_q, rd_id_d, rd_cnt_q, rd_cnt_d;
  logic [MEM_AW-1:0] rd_idx_q, rd_idx_d;
  wr_state_e         wr_state_q, wr_state_d;
  logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [MEM_AW-1:0] wr_idx_q, wr_idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              live_q;
  logic              stall;

  logic              sram_re, sram_we;
  logic [MEM_AW-1:0] sram_raddr, sram_waddr;
  logic [31:0]       sram_rdata, sram_wdata;
  logic [3:0]        sram_wstrb;

`ifdef AXI_SLAVE_STALL_EN
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr_q <= STALL_SEED;
    else          lfsr_q <= lfsr_d;
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{s_axi_awsize, s_axi_arsize, s_axi_awaddr[31:MEM_AW+2], s_axi_awaddr[1:0],
                         s_axi_araddr[31:MEM_AW+2], s_axi_araddr[1:0], STALL_SEED};

  // live_q keeps the readies low until the first edge after reset release
  assign s_axi_arready = live_q & ~stall & (rd_state_q == RD_IDLE);
  assign s_axi_awready = live_q & ~stall & (wr_state_q == WR_IDLE) & ~aw_got_q;
  assign s_axi_wready  = live_q & ~stall & (wr_state_q == WR_IDLE) & ~w_got_q;
  assign s_axi_bvalid  = (wr_state_q == WR_RESP);
  assign s_axi_rvalid  = (rd_state_q == RD_DATA);
  assign s_axi_rlast   = s_axi_rvalid & (rd_cnt_q == 4'd0);
  assign s_axi_rid     = rd_id_q;
  assign s_axi_rdata   = s_axi_rvalid ? sram_rdata : 32'h0;

  always_comb begin
    rd_state_d = rd_state_q;
    rd_id_d    = rd_id_q;
    rd_idx_d   = rd_idx_q;
    rd_cnt_d   = rd_cnt_q;
    sram_re    = 1'b0;
    sram_raddr = rd_idx_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (s_axi_arvalid && s_axi_arready) begin
          rd_id_d    = s_axi_arid;
          rd_idx_d   = s_axi_araddr[MEM_AW+1:2];
          rd_cnt_d   = s_axi_arlen;
          rd_state_d = RD_FETCH;
        end
      end
      RD_FETCH: begin
        if (!stall) begin
          sram_re    = 1'b1;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (s_axi_rready) begin
          if (rd_cnt_q == 4'd0) begin
            rd_state_d = RD_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
            rd_cnt_d = rd_cnt_q - 4'd1;
            // Under stall the beat just delivered ends rvalid; refetch later
            if (stall) begin
              rd_state_d = RD_FETCH;
            end else begin
              sram_re    = 1'b1;
              sram_raddr = rd_idx_d;
            end
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    wr_idx_d   = wr_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    sram_we    = 1'b0;
    if (s_axi_awvalid && s_axi_awready) wr_idx_d = s_axi_awaddr[MEM_AW+1:2];
    if (s_axi_wvalid && s_axi_wready) begin
      wdata_d = s_axi_wdata;
      wstrb_d = s_axi_wstrb;
    end
    case (wr_state_q)
      WR_IDLE: begin
        aw_got_d = aw_got_q | (s_axi_awvalid & s_axi_awready);
        w_got_d  = w_got_q | (s_axi_wvalid & s_axi_wready);
        if (aw_got_d && w_got_d && !stall) begin
          sram_we    = 1'b1;
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: if (s_axi_bready) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // A channel accepted this very cycle is written straight from the bus
  assign sram_waddr = aw_got_q ? wr_idx_q : s_axi_awaddr[MEM_AW+1:2];
  assign sram_wdata = w_got_q ? wdata_q : s_axi_wdata;
  assign sram_wstrb = w_got_q ? wstrb_q : s_axi_wstrb;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live_q     <= 1'b0;
      rd_state_q <= RD_IDLE;
      rd_id_q    <= '0;
      rd_idx_q   <= '0;
      rd_cnt_q   <= '0;
      wr_state_q <= WR_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      wr_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      live_q     <= 1'b1;
      rd_state_q <= rd_state_d;
      rd_id_q    <= rd_id_d;
      rd_idx_q   <= rd_idx_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_state_q <= wr_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      wr_idx_q   <= wr_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  sram_1r1w_be #(.AW(MEM_AW)) u_sram (
    .clk   (aclk),
    .re    (sram_re),
    .raddr (sram_raddr),
    .rdata (sram_rdata),
    .we    (sram_we),
    .waddr (sram_waddr),
    .wdata (sram_wdata),
    .wstrb (sram_wstrb)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: directed cases plus random reads/writes
// checked against a word-array memory model.
module tb_axi_sram_slave;

  localparam int MEM_AW = 12;
  localparam int DEPTH  = 1 << MEM_AW;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_axi_awaddr = '0;
  logic [2:0]  s_axi_awsize = 3'd2;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b1;
  logic [3:0]  s_axi_arid = '0;
  logic [31:0] s_axi_araddr = '0;
  logic [3:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = 3'd2;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [3:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  axi_sram_slave #(.MEM_AW(MEM_AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awsize(s_axi_awsize),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] model [DEPTH];

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic        last;
  } rbeat_t;

  rbeat_t rq[$];
  int     beat_cyc[$];
  int     b_cyc[$];
  int     b_exp = 0;
  int     rmode = 0;

  logic        hold_seen = 1'b0;
  logic [31:0] hold_data;
  logic [3:0]  hold_id;
  logic        hold_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // rready pattern: 0 held high, 1 toggling, 2 random
  initial begin
    s_axi_rready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rmode)
        0:       s_axi_rready = 1'b1;
        1:       s_axi_rready = ~s_axi_rready;
        default: s_axi_rready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every R/B handshake
  initial begin
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        hold_seen = 1'b0;
      end else begin
        if (hold_seen) begin
          check("r_stall_valid", s_axi_rvalid, 1);
          check("r_stall_data", s_axi_rdata, hold_data);
          check("r_stall_id", s_axi_rid, hold_id);
          check("r_stall_last", s_axi_rlast, hold_last);
        end
        hold_seen = 1'b0;
        if (s_axi_rvalid && s_axi_rready) begin
          rbeat_t e;
          check("r_beat_expected", rq.size() > 0, 1);
          if (rq.size() > 0) begin
            e = rq.pop_front();
            check("r_data", s_axi_rdata, e.data);
            check("r_id", s_axi_rid, e.id);
            check("r_last", s_axi_rlast, e.last);
          end
          beat_cyc.push_back(cyc);
        end else if (s_axi_rvalid) begin
          hold_seen = 1'b1;
          hold_data = s_axi_rdata;
          hold_id   = s_axi_rid;
          hold_last = s_axi_rlast;
        end
        if (s_axi_bvalid) begin
          check("b_awready_low", s_axi_awready, 0);
          check("b_wready_low", s_axi_wready, 0);
        end
        if (s_axi_bvalid && s_axi_bready) begin
          check("b_expected", b_exp > 0, 1);
          if (b_exp > 0) b_exp--;
          b_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] rand_addr(input int idx);
    logic [31:0] mask;
    mask = 32'((DEPTH - 1) << 2);
    return ($urandom & ~mask) | 32'(idx << 2);
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_rmode(input int m);
    rmode = m;
    tick();
    tick();
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         output int hs);
    int t;
    int base;
    base = word_of(addr);
    for (int k = 0; k <= int'(len); k++) begin
      rbeat_t e;
      e.id   = id;
      e.data = model[(base + k) % DEPTH];
      e.last = (k == int'(len));
      rq.push_back(e);
    end
    s_axi_arid    = id;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arsize  = 3'($urandom_range(0, 7));
    s_axi_arvalid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!s_axi_arready && t < 200) begin
      @(negedge aclk);
      t++;
    end
    check("ar_accept_timeout", t < 200, 1);
    hs = cyc;
    tick();
    s_axi_arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input int aw_dly, input int w_dly, output int aw_hs, output int w_hs);
    int base;
    int a_c;
    int w_c;
    base = word_of(addr);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) model[base][8*b +: 8] = data[8*b +: 8];
    end
    b_exp++;
    a_c = 0;
    w_c = 0;
    fork
      begin
        int t;
        t = 0;
        repeat (aw_dly) tick();
        s_axi_awaddr  = addr;
        s_axi_awsize  = 3'($urandom_range(0, 7));
        s_axi_awvalid = 1'b1;
        @(negedge aclk);
        while (!s_axi_awready && t < 200) begin
          @(negedge aclk);
          t++;
        end
        check("aw_accept_timeout", t < 200, 1);
        a_c = cyc;
        tick();
        s_axi_awvalid = 1'b0;
      end
      begin
        int t;
        t = 0;
        repeat (w_dly) tick();
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        s_axi_wvalid = 1'b1;
        @(negedge aclk);
        while (!s_axi_wready && t < 200) begin
          @(negedge aclk);
          t++;
        end
        check("w_accept_timeout", t < 200, 1);
        w_c = cyc;
        tick();
        s_axi_wvalid = 1'b0;
      end
    join
    aw_hs = a_c;
    w_hs  = w_c;
  endtask

  task automatic wait_b(output int c);
    int t;
    t = 0;
    while (b_cyc.size() == 0 && t < 200) begin
      @(negedge aclk);
      t++;
    end
    check("b_timeout", t < 200, 1);
    c = (b_cyc.size() > 0) ? b_cyc.pop_front() : -1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((rq.size() != 0 || b_exp != 0) && t < 500) begin
      @(negedge aclk);
      t++;
    end
    check("drain_timeout", t < 500, 1);
    rq.delete();
    b_exp = 0;
    tick();
  endtask

  initial begin
    int hs, aw_hs, w_hs, bc, nb, base, len, idx;
    rbeat_t e;

    // Reset values and ready release timing
    repeat (3) tick();
    @(negedge aclk);
    check("rst_arready", s_axi_arready, 0);
    check("rst_awready", s_axi_awready, 0);
    check("rst_wready", s_axi_wready, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_rlast", s_axi_rlast, 0);
    check("rst_rdata", s_axi_rdata, 0);
    check("rst_rid", s_axi_rid, 0);
    tick();
    aresetn = 1'b1;
    @(negedge aclk);
    check("rel_readies_before_edge", {s_axi_arready, s_axi_awready, s_axi_wready}, 3'b000);
    @(negedge aclk);
    check("rel_readies_after_edge", {s_axi_arready, s_axi_awready, s_axi_wready}, 3'b111);
    tick();

    // Single write then single read
    b_cyc.delete();
    beat_cyc.delete();
    send_w(32'h100, 32'hDEADBEEF, 4'hF, 0, 0, aw_hs, w_hs);
    @(negedge aclk);
    check("t1_bvalid", s_axi_bvalid, 1);
    check("t1_awready_low", s_axi_awready, 0);
    tick();
    @(negedge aclk);
    check("t1_awready_back", s_axi_awready, 1);
    wait_b(bc);
    check("t1_b_latency", bc, aw_hs + 1);
    tick();
    send_ar(4'd3, 32'h100, 4'd0, hs);
    drain();
    check("t1_r_latency", beat_cyc.size() > 0 ? beat_cyc[0] : -1, hs + 2);

    // Burst preload and full-rate 16-beat read
    for (int i = 0; i < 16; i++) begin
      send_w(32'h200 + 32'(4 * i), 32'h80 + 32'(i), 4'hF, 0, 0, aw_hs, w_hs);
      wait_b(bc);
    end
    drain();
    set_rmode(0);
    beat_cyc.delete();
    send_ar(4'hA, 32'h200, 4'd15, hs);
    drain();
    check("t2_beats", beat_cyc.size(), 16);
    check("t2_first", beat_cyc.size() == 16 ? beat_cyc[0] : -1, hs + 2);
    check("t2_last", beat_cyc.size() == 16 ? beat_cyc[15] : -1, hs + 17);

    // Same burst under toggling rready
    set_rmode(1);
    beat_cyc.delete();
    send_ar(4'h5, 32'h200, 4'd15, hs);
    drain();
    check("t3_beats", beat_cyc.size(), 16);
    set_rmode(0);

    // Byte strobes, then a zero-strobe write
    b_cyc.delete();
    send_w(32'h40, 32'h11223344, 4'hF, 0, 0, aw_hs, w_hs);
    wait_b(bc);
    send_w(32'h40, 32'hAABBCCDD, 4'b0101, 0, 0, aw_hs, w_hs);
    wait_b(bc);
    drain();
    send_ar(4'd1, 32'h40, 4'd0, hs);
    drain();
    send_w(32'h40, 32'hFFFFFFFF, 4'h0, 0, 0, aw_hs, w_hs);
    wait_b(bc);
    check("t4_strb0_b_latency", bc, aw_hs + 1);
    drain();
    send_ar(4'd2, 32'h40, 4'd0, hs);
    drain();

    // W leads AW by four cycles, B held off for three cycles
    s_axi_bready = 1'b0;
    b_cyc.delete();
    send_w(32'h44, 32'hCAFEF00D, 4'hF, 4, 0, aw_hs, w_hs);
    check("t5_order", aw_hs - w_hs, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("t5_bvalid_held", s_axi_bvalid, 1);
      check("t5_awready_low", s_axi_awready, 0);
      check("t5_wready_low", s_axi_wready, 0);
      tick();
    end
    s_axi_bready = 1'b1;
    wait_b(bc);
    check("t5_b_cycle", bc, aw_hs + 4);
    tick();
    @(negedge aclk);
    check("t5_readies_back", {s_axi_awready, s_axi_wready}, 2'b11);
    tick();
    drain();

    // Write lands on the same edge as the fetch of that word
    e.id   = 4'd2;
    e.data = model[word_of(32'h200)];
    e.last = 1'b1;
    rq.push_back(e);
    s_axi_arid    = 4'd2;
    s_axi_araddr  = 32'h200;
    s_axi_arlen   = 4'd0;
    s_axi_arvalid = 1'b1;
    @(negedge aclk);
    check("t6_arready", s_axi_arready, 1);
    tick();
    s_axi_arvalid = 1'b0;
    s_axi_awaddr  = 32'h200;
    s_axi_wdata   = 32'h5;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    @(negedge aclk);
    check("t6_awready", s_axi_awready, 1);
    check("t6_wready", s_axi_wready, 1);
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    model[word_of(32'h200)] = 32'h5;
    b_exp++;
    drain();
    send_ar(4'd3, 32'h200, 4'd0, hs);
    drain();

    // Reset in the middle of an 8-beat burst
    beat_cyc.delete();
    send_ar(4'd7, 32'h200, 4'd7, hs);
    for (int t = 0; t < 50 && beat_cyc.size() < 3; t++) @(negedge aclk);
    check("t7_beats_before_reset", beat_cyc.size() >= 3, 1);
    #2;
    aresetn = 1'b0;
    rq.delete();
    b_exp = 0;
    #1;
    check("t7_rvalid_async", s_axi_rvalid, 0);
    check("t7_arready_async", s_axi_arready, 0);
    tick();
    tick();
    aresetn = 1'b1;
    nb = beat_cyc.size();
    @(negedge aclk);
    check("t7_arready_before_edge", s_axi_arready, 0);
    @(negedge aclk);
    check("t7_arready_after_edge", s_axi_arready, 1);
    repeat (20) tick();
    check("t7_no_beats_after_reset", beat_cyc.size(), nb);

    // Random traffic over a written pool, including index wrap and address aliasing
    for (int i = 0; i < 16; i++) begin
      send_w(rand_addr(i), $urandom, 4'hF, 0, 0, aw_hs, w_hs);
      wait_b(bc);
      send_w(rand_addr(DEPTH - 8 + (i % 8)), $urandom, 4'hF, 0, 0, aw_hs, w_hs);
      wait_b(bc);
    end
    drain();
    set_rmode(2);
    b_cyc.delete();
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        idx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15))
                                          : DEPTH - 8 + int'($urandom_range(0, 7));
        send_w(rand_addr(idx), $urandom, 4'($urandom), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), aw_hs, w_hs);
        wait_b(bc);
        check("rnd_b_latency", bc, ((aw_hs > w_hs) ? aw_hs : w_hs) + 1);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          base = DEPTH - 8 + int'($urandom_range(0, 7));
          len  = int'($urandom_range(0, 15));
        end else begin
          base = int'($urandom_range(0, 15));
          len  = int'($urandom_range(0, 15 - base));
        end
        send_ar(4'($urandom), rand_addr(base), 4'(len), hs);
      end
      drain();
    end
    set_rmode(0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
